// File: rtl/led_sched.sv
// Round-robin scheduler that lends the LED multiplex driver to one of four clients
// at a time, with a minimum hold slot and a dark gap between owners.
module led_sched #(
    parameter int unsigned HOLD_CYCLES  = 12000000,
    parameter int unsigned BLANK_CYCLES = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [47:0] yr_in,
    input  logic [47:0] bg_in,
    output logic [3:0]  gnt,
    output logic [11:0] led_in_yr,
    output logic [11:0] led_in_bg,
    output logic        busy
);

    localparam int unsigned HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
    localparam int unsigned BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLANK_W-1:0] BLANK_MAX = BLANK_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t               r_state;
    logic [1:0]           r_ptr;
    logic [1:0]           r_owner;
    logic [HOLD_W-1:0]    r_hold;
    logic [BLANK_W-1:0]   r_blank;

    logic [1:0]           w_win;
    logic [3:0]           w_win_oh;
    logic [3:0]           w_owner_oh;
    logic                 w_own_req;
    logic                 w_rival;
    logic [11:0]          w_owner_yr;
    logic [11:0]          w_owner_bg;

    // First requester at or after ptr; scanning downward lets the nearest one win.
    always_comb begin
        w_win = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[r_ptr + 2'(i)]) begin
                w_win = r_ptr + 2'(i);
            end
        end
    end

    assign w_win_oh   = 4'b0001 << w_win;
    assign w_owner_oh = 4'b0001 << r_owner;
    assign w_own_req  = req[r_owner];
    assign w_rival    = |(req & ~w_owner_oh);
    assign w_owner_yr = yr_in[12*r_owner +: 12];
    assign w_owner_bg = bg_in[12*r_owner +: 12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd0;
            r_owner   <= 2'd0;
            r_hold    <= '0;
            r_blank   <= '0;
            gnt       <= 4'd0;
            led_in_yr <= 12'd0;
            led_in_bg <= 12'd0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_state <= ST_OWN;
                        r_owner <= w_win;
                        gnt     <= w_win_oh;
                        r_hold  <= '0;
                        busy    <= 1'b1;
                    end
                end

                ST_OWN: begin
                    led_in_yr <= w_owner_yr;
                    led_in_bg <= w_owner_bg;
                    // Owner drop wins over hold expiry; both land in BLANK identically.
                    if (!w_own_req || ((r_hold == HOLD_MAX) && w_rival)) begin
                        r_state   <= ST_BLANK;
                        r_ptr     <= r_owner + 2'd1;
                        r_blank   <= '0;
                        gnt       <= 4'd0;
                        led_in_yr <= 12'd0;
                        led_in_bg <= 12'd0;
                    end else if (r_hold != HOLD_MAX) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end

                ST_BLANK: begin
                    if (r_blank == BLANK_MAX) begin
                        if (|req) begin
                            r_state <= ST_OWN;
                            r_owner <= w_win;
                            gnt     <= w_win_oh;
                            r_hold  <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_blank <= r_blank + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    gnt     <= 4'd0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_sched.sv
// Directed bench for led_sched with HOLD_CYCLES=8, BLANK_CYCLES=2.
module tb_led_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [47:0] yr_in;
    logic [47:0] bg_in;
    logic [3:0]  gnt;
    logic [11:0] led_in_yr;
    logic [11:0] led_in_bg;
    logic        busy;

    int total;
    int bad;

    led_sched #(
        .HOLD_CYCLES (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .yr_in    (yr_in),
        .bg_in    (bg_in),
        .gnt      (gnt),
        .led_in_yr(led_in_yr),
        .led_in_bg(led_in_bg),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'd0;
        yr_in = 48'd0;
        bg_in = 48'd0;
        #12;
        total++; if (gnt !== 4'd0) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        total++; if (led_in_yr !== 12'd0) begin bad++; $display("FAIL reset_yr got=%h want=000", led_in_yr); end
        total++; if (led_in_bg !== 12'd0) begin bad++; $display("FAIL reset_bg got=%h want=000", led_in_bg); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_single();
        yr_in = {12'h000, 12'hA5A, 12'h000, 12'h000};
        bg_in = {12'h000, 12'h3C3, 12'h000, 12'h000};
        req   = 4'b0100;
        step(1);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b want=0100", gnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        total++; if (led_in_yr !== 12'h000) begin bad++; $display("FAIL single_yr_lag got=%h want=000", led_in_yr); end
        step(1);
        total++; if (led_in_yr !== 12'hA5A) begin bad++; $display("FAIL single_yr got=%h want=a5a", led_in_yr); end
        total++; if (led_in_bg !== 12'h3C3) begin bad++; $display("FAIL single_bg got=%h want=3c3", led_in_bg); end
        step(110);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_persist got=%b want=0100", gnt); end
        // Owner drops with nobody else waiting: two dark cycles then idle.
        req = 4'b0000;
        step(1);
        total++; if (gnt !== 4'd0) begin bad++; $display("FAIL empty_blank_gnt got=%b want=0000", gnt); end
        total++; if (led_in_yr !== 12'd0) begin bad++; $display("FAIL empty_blank_yr got=%h want=000", led_in_yr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL empty_blank_busy got=%b want=1", busy); end
        step(1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL empty_blank2_busy got=%b want=1", busy); end
        step(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL empty_idle_busy got=%b want=0", busy); end
        total++; if (gnt !== 4'd0 || led_in_yr !== 12'd0 || led_in_bg !== 12'd0) begin
            bad++; $display("FAIL empty_idle_out got gnt=%b yr=%h bg=%h want all 0", gnt, led_in_yr, led_in_bg);
        end
    endtask

    task automatic test_round_robin();
        logic [11:0] exp_yr [4];
        logic [11:0] exp_bg [4];
        logic [3:0]  exp_gnt;
        int          who;
        exp_yr[0] = 12'h111; exp_yr[1] = 12'h222; exp_yr[2] = 12'h333; exp_yr[3] = 12'h444;
        exp_bg[0] = 12'hEEE; exp_bg[1] = 12'hDDD; exp_bg[2] = 12'hCCC; exp_bg[3] = 12'hBBB;
        yr_in = {exp_yr[3], exp_yr[2], exp_yr[1], exp_yr[0]};
        bg_in = {exp_bg[3], exp_bg[2], exp_bg[1], exp_bg[0]};
        pulse_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            who     = k % 4;
            exp_gnt = 4'b0001 << who;
            for (int c = 0; c < 8; c++) begin
                step(1);
                total++; if (gnt !== exp_gnt) begin
                    bad++; $display("FAIL rr_gnt k=%0d c=%0d got=%b want=%b", k, c, gnt, exp_gnt);
                end
                if (c >= 1) begin
                    total++; if (led_in_yr !== exp_yr[who] || led_in_bg !== exp_bg[who]) begin
                        bad++; $display("FAIL rr_led k=%0d c=%0d got=%h/%h want=%h/%h",
                                        k, c, led_in_yr, led_in_bg, exp_yr[who], exp_bg[who]);
                    end
                end
            end
            if (k < 4) begin
                for (int c = 0; c < 2; c++) begin
                    step(1);
                    total++; if (gnt !== 4'd0 || led_in_yr !== 12'd0 || led_in_bg !== 12'd0) begin
                        bad++; $display("FAIL rr_blank k=%0d c=%0d got gnt=%b yr=%h bg=%h want all 0",
                                        k, c, gnt, led_in_yr, led_in_bg);
                    end
                end
            end
        end
        req = 4'b0000;
        step(4);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_end_busy got=%b want=0", busy); end
    endtask

    task automatic test_early_drop();
        pulse_reset();
        req = 4'b0010;
        step(1);
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL drop_own got=%b want=0010", gnt); end
        req = 4'b1011;
        step(3);
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL drop_hold3 got=%b want=0010", gnt); end
        req = 4'b1001;
        step(1);
        total++; if (gnt !== 4'd0) begin bad++; $display("FAIL drop_blank1 got=%b want=0000", gnt); end
        // Requests vanishing mid-gap must not push the block to idle early.
        req = 4'b0000;
        step(1);
        total++; if (gnt !== 4'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL drop_blank2 got gnt=%b busy=%b want 0000/1", gnt, busy);
        end
        req = 4'b1001;
        step(1);
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL drop_next got=%b want=1000", gnt); end
        req = 4'b0000;
        step(4);
    endtask

    task automatic test_reset_mid_own();
        yr_in = {12'h000, 12'h777, 12'h000, 12'h000};
        bg_in = {12'h000, 12'h888, 12'h000, 12'h000};
        pulse_reset();
        req = 4'b0100;
        step(3);
        total++; if (gnt !== 4'b0100 || led_in_yr !== 12'h777) begin
            bad++; $display("FAIL rst_pre got gnt=%b yr=%h want 0100/777", gnt, led_in_yr);
        end
        rst_n = 1'b0;
        #1;
        total++; if (gnt !== 4'd0 || led_in_yr !== 12'd0 || led_in_bg !== 12'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_async got gnt=%b yr=%h bg=%h busy=%b want all 0",
                            gnt, led_in_yr, led_in_bg, busy);
        end
        #3;
        rst_n = 1'b1;
        req   = 4'b0110;
        step(1);
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rst_ptr0 got=%b want=0010", gnt); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_early_drop();
        test_reset_mid_own();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
